// File: rtl/alu_sequencer.sv
// alu_sequencer: request/response front end for the combinational 64-bit alu.
// Accepts one op per handshake, decodes ALUOp/opcode to a 4-bit control code,
// drives the alu from registers, captures result/zero one cycle later and
// returns them on a valid/ready response channel. Counts completed responses.
module alu_sequencer #(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [10:0]      req_opcode,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_control,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_zero,
  output logic             rsp_error,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  logic [1:0] state;
  logic       dec_ok;
  logic [3:0] dec_ctl;

  // Handshake flags come straight from state so neither side sees a comb path.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Decode ALUOp + R-format opcode into the alu control code; flag anything else.
  always_comb begin
    dec_ok  = 1'b1;
    dec_ctl = 4'b0000;
    case (req_aluop)
      2'b00: dec_ctl = 4'b0010;
      2'b01: dec_ctl = 4'b0111;
      2'b10: begin
        case (req_opcode)
          OP_ADD:  dec_ctl = 4'b0010;
          OP_SUB:  dec_ctl = 4'b0110;
          OP_AND:  dec_ctl = 4'b0000;
          OP_ORR:  dec_ctl = 4'b0001;
          default: dec_ok  = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // FSM: IDLE accepts, EXEC lets the alu settle and captures, RESP holds until taken.
  // Illegal requests jump straight to RESP and leave the alu registers untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 4'b0000;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_error   <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (dec_ok) begin
              alu_a       <= req_a;
              alu_b       <= req_b;
              alu_control <= dec_ctl;
              state       <= EXEC;
            end else begin
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_error  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_error  <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural alu hanging off its outputs.
module tb_alu_sequencer;

  localparam int N     = 64;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [10:0]      req_opcode;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [3:0]       alu_control;
  logic [N-1:0]     alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic             rsp_zero;
  logic             rsp_error;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;

  alu_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_error(rsp_error),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational alu datapath.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  // Present one request for a single edge, then drop req_valid.
  task automatic send(input logic [1:0] op, input logic [10:0] opc,
                      input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid = 1'b1; req_aluop = op; req_opcode = opc; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Take the response in one cycle.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if ({alu_a, alu_b, alu_control} !== '0) begin bad++; $display("FAIL reset_alu_regs a=%0h b=%0h c=%0b exp=0", alu_a, alu_b, alu_control); end
    total++; if ({rsp_result, rsp_zero, rsp_error} !== '0) begin bad++; $display("FAIL reset_rsp got=%0h z=%0b e=%0b exp=0", rsp_result, rsp_zero, rsp_error); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", op_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(2'b10, OP_ADD, 64'd23, 64'd23);
    total++; if (alu_control !== 4'b0010) begin bad++; $display("FAIL add_ctl got=%0b exp=0010", alu_control); end
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL add_exec_flags vld=%0b rdy=%0b exp=0/0", rsp_valid, req_ready); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL add_latency rsp_valid=%0b exp=1", rsp_valid); end
    total++; if (rsp_result !== 64'd46 || rsp_zero !== 1'b0 || rsp_error !== 1'b0) begin bad++; $display("FAIL add_result got=%0d z=%0b e=%0b exp=46/0/0", rsp_result, rsp_zero, rsp_error); end
    take_rsp();
    total++; if (op_count !== 16'd1 || req_ready !== 1'b1) begin bad++; $display("FAIL add_count cnt=%0d rdy=%0b exp=1/1", op_count, req_ready); end
  endtask

  task automatic test_sub_zero();
    send(2'b10, OP_SUB, 64'd23, 64'd5);
    total++; if (alu_control !== 4'b0110) begin bad++; $display("FAIL sub_ctl got=%0b exp=0110", alu_control); end
    @(posedge clk); #1;
    total++; if (rsp_result !== 64'd18 || rsp_zero !== 1'b0) begin bad++; $display("FAIL sub_result got=%0d z=%0b exp=18/0", rsp_result, rsp_zero); end
    take_rsp();
    send(2'b10, OP_SUB, 64'd23, 64'd23);
    @(posedge clk); #1;
    total++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%0d z=%0b exp=0/1", rsp_result, rsp_zero); end
    take_rsp();
    total++; if (op_count !== 16'd3) begin bad++; $display("FAIL sub_count got=%0d exp=3", op_count); end
  endtask

  task automatic test_overflow();
    send(2'b00, 11'h7FF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    total++; if (alu_control !== 4'b0010) begin bad++; $display("FAIL ovf_ctl got=%0b exp=0010", alu_control); end
    @(posedge clk); #1;
    total++; if (rsp_result !== 64'hFFFF_FFFF_FFFF_FFFE || rsp_zero !== 1'b0 || rsp_error !== 1'b0) begin bad++; $display("FAIL ovf_result got=%0h z=%0b e=%0b exp=fffffffffffffffe/0/0", rsp_result, rsp_zero, rsp_error); end
    take_rsp();
  endtask

  task automatic test_logic_cbz();
    send(2'b10, OP_AND, 64'd1, 64'd2);
    total++; if (alu_control !== 4'b0000) begin bad++; $display("FAIL and_ctl got=%0b exp=0000", alu_control); end
    @(posedge clk); #1;
    total++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin bad++; $display("FAIL and_result got=%0d z=%0b exp=0/1", rsp_result, rsp_zero); end
    take_rsp();
    send(2'b10, OP_ORR, 64'd1, 64'd2);
    total++; if (alu_control !== 4'b0001) begin bad++; $display("FAIL orr_ctl got=%0b exp=0001", alu_control); end
    @(posedge clk); #1;
    total++; if (rsp_result !== 64'd3 || rsp_zero !== 1'b0) begin bad++; $display("FAIL orr_result got=%0d z=%0b exp=3/0", rsp_result, rsp_zero); end
    take_rsp();
    send(2'b01, 11'd0, 64'd5, 64'd0);
    total++; if (alu_control !== 4'b0111) begin bad++; $display("FAIL cbz_ctl got=%0b exp=0111", alu_control); end
    @(posedge clk); #1;
    total++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin bad++; $display("FAIL cbz_result got=%0d z=%0b exp=0/1", rsp_result, rsp_zero); end
    take_rsp();
    total++; if (op_count !== 16'd7) begin bad++; $display("FAIL logic_count got=%0d exp=7", op_count); end
  endtask

  task automatic test_error_backpressure();
    send(2'b11, OP_ADD, 64'd99, 64'd77);
    total++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin bad++; $display("FAIL err_rsp vld=%0b err=%0b exp=1/1", rsp_valid, rsp_error); end
    total++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b0) begin bad++; $display("FAIL err_result got=%0d z=%0b exp=0/0", rsp_result, rsp_zero); end
    total++; if (alu_a !== 64'd5 || alu_b !== 64'd0 || alu_control !== 4'b0111) begin bad++; $display("FAIL err_alu_hold a=%0d b=%0d c=%0b exp=5/0/0111", alu_a, alu_b, alu_control); end
    // A legal request offered while busy must be ignored.
    req_valid = 1'b1; req_aluop = 2'b10; req_opcode = OP_ADD; req_a = 64'd1; req_b = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_error !== 1'b1 || rsp_result !== 64'd0 || rsp_zero !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d vld=%0b rdy=%0b err=%0b res=%0d z=%0b", i, rsp_valid, req_ready, rsp_error, rsp_result, rsp_zero);
      end
      total++; if (alu_a !== 64'd5 || alu_control !== 4'b0111) begin bad++; $display("FAIL bp_alu_hold cyc=%0d a=%0d c=%0b exp=5/0111", i, alu_a, alu_control); end
    end
    req_valid = 1'b0;
    total++; if (op_count !== 16'd7) begin bad++; $display("FAIL bp_count_before got=%0d exp=7", op_count); end
    take_rsp();
    total++; if (op_count !== 16'd8 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release cnt=%0d rdy=%0b vld=%0b exp=8/1/0", op_count, req_ready, rsp_valid); end
    @(posedge clk); #1;
    total++; if (op_count !== 16'd8) begin bad++; $display("FAIL bp_count_once got=%0d exp=8", op_count); end
  endtask

  task automatic test_reset_mid_op();
    send(2'b10, OP_ADD, 64'd10, 64'd20);
    total++; if (req_ready !== 1'b0 || alu_a !== 64'd10) begin bad++; $display("FAIL rst_in_exec rdy=%0b a=%0d exp=0/10", req_ready, alu_a); end
    reset = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== 16'd0) begin bad++; $display("FAIL rst_async vld=%0b rdy=%0b cnt=%0d exp=0/1/0", rsp_valid, req_ready, op_count); end
    total++; if ({alu_a, alu_b, alu_control} !== '0) begin bad++; $display("FAIL rst_alu_regs a=%0d b=%0d c=%0b exp=0", alu_a, alu_b, alu_control); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp vld=%0b exp=0", rsp_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
    send(2'b10, OP_ADD, 64'd23, 64'd23);
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd46) begin bad++; $display("FAIL rst_after_add vld=%0b res=%0d exp=1/46", rsp_valid, rsp_result); end
    take_rsp();
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL rst_after_count got=%0d exp=1", op_count); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_aluop = 2'b00; req_opcode = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_zero();
    test_overflow();
    test_logic_cbz();
    test_error_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
